// File: rtl/sccomp_dbg_ctrl.sv
// sccomp_dbg_ctrl: run/step/halt/dump debug controller gating the sccomp CPU clock enable
module sccomp_dbg_ctrl #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int SW = 16,
  parameter int NREG = 32,
  localparam int RW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [SW-1:0] cmd_arg,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] pc,
  output logic          cpu_ce,
  output logic [RW-1:0] reg_sel,
  input  logic [DW-1:0] reg_data,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [RW-1:0] dump_idx,
  output logic [DW-1:0] dump_data,
  output logic          halted,
  output logic [31:0]   cycle_cnt
);
  typedef enum logic [2:0] {S_HALT, S_RUN, S_STEP, S_DSEL, S_DOUT} state_t;
  state_t state, nxt;
  logic first, acc, bp_hit, last;
  logic [SW-1:0] cnt;
  assign cmd_ready = ~rst & (state == S_HALT | state == S_RUN);
  assign acc = cmd_valid & cmd_ready;
  // first suppresses the breakpoint so a run can resume from the breakpoint PC
  assign bp_hit = bp_en & (pc == bp_addr) & ~first;
  assign cpu_ce = state == S_STEP | (state == S_RUN & ~bp_hit);
  assign last = reg_sel == RW'(NREG - 1);
  always_comb begin
    nxt = state;
    case (state)
      S_HALT: nxt = !acc ? S_HALT : cmd_op == 2'b00 ? S_RUN : cmd_op == 2'b01 ? S_STEP :
                    cmd_op == 2'b11 ? S_DSEL : S_HALT;
      S_RUN:  nxt = (bp_hit | (acc & cmd_op == 2'b10)) ? S_HALT : S_RUN;
      S_STEP: nxt = cnt == SW'(1) ? S_HALT : S_STEP;
      S_DSEL: nxt = S_DOUT;
      S_DOUT: nxt = !dump_ready ? S_DOUT : last ? S_HALT : S_DSEL;
      default: nxt = S_HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_HALT;
      halted <= 1'b1;
      first <= 1'b0;
      cnt <= '0;
      reg_sel <= '0;
      dump_valid <= 1'b0;
      dump_idx <= '0;
      dump_data <= '0;
      cycle_cnt <= '0;
    end else begin
      state <= nxt;
      halted <= nxt == S_HALT;
      first <= state == S_HALT & nxt == S_RUN;
      if (cpu_ce) cycle_cnt <= cycle_cnt + 32'd1;
      if (state == S_HALT & acc & cmd_op == 2'b01) cnt <= cmd_arg == '0 ? SW'(1) : cmd_arg;
      else if (state == S_STEP) cnt <= cnt - SW'(1);
      if (state == S_HALT & nxt == S_DSEL) reg_sel <= '0;
      if (state == S_DSEL) begin
        dump_data <= reg_data;
        dump_idx <= reg_sel;
        dump_valid <= 1'b1;
      end
      if (state == S_DOUT & dump_ready) begin
        dump_valid <= 1'b0;
        reg_sel <= last ? '0 : reg_sel + RW'(1);
      end
    end
  end
endmodule

// File: tb/tb_sccomp_dbg_ctrl.sv
// tb_sccomp_dbg_ctrl: directed self-checking bench for the debug controller
module tb_sccomp_dbg_ctrl;
  logic clk = 0, rst = 1, cmd_valid = 0, bp_en = 0, dump_ready = 0;
  logic [1:0] cmd_op = 0;
  logic [15:0] cmd_arg = 0;
  logic [31:0] bp_addr = 0, pc = 0, reg_data, dump_data, cycle_cnt;
  logic [4:0] reg_sel, dump_idx;
  logic cmd_ready, cpu_ce, dump_valid, halted;
  int errors = 0, checks = 0, hs, exp_idx;
  assign reg_data = 32'hA500_0000 | 32'(reg_sel);
  always #5 clk = ~clk;
  sccomp_dbg_ctrl dut (.clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_ce(cpu_ce), .reg_sel(reg_sel), .reg_data(reg_data), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data), .halted(halted),
    .cycle_cnt(cycle_cnt));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic cmd(input logic [1:0] op, input logic [15:0] arg);
    cmd_valid = 1; cmd_op = op; cmd_arg = arg;
  endtask
  task automatic do_reset();
    rst = 1; cmd_valid = 0; tick(); rst = 0;
  endtask
  initial begin
    #1; chk("ready_in_rst", 32'(cmd_ready), 0);
    do_reset();
    chk("rst_halted", 32'(halted), 1);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_valid", 32'(dump_valid), 0);
    for (int i = 0; i < 10; i++) begin
      #1; chk("idle_ce", 32'(cpu_ce), 0); chk("idle_halted", 32'(halted), 1); tick();
    end
    chk("idle_cnt", cycle_cnt, 0);
    cmd(2'b01, 16'd3); #1; chk("step_ready", 32'(cmd_ready), 1); tick(); cmd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1; chk("step3_ce", 32'(cpu_ce), 1); chk("step3_ready", 32'(cmd_ready), 0); tick();
    end
    #1; chk("step3_done_ce", 32'(cpu_ce), 0); chk("step3_halted", 32'(halted), 1);
    chk("step3_cnt", cycle_cnt, 3);
    cmd(2'b01, 16'd0); tick(); cmd_valid = 0;
    #1; chk("step0_ce", 32'(cpu_ce), 1); tick();
    #1; chk("step0_done_ce", 32'(cpu_ce), 0); chk("step0_cnt", cycle_cnt, 4);
    do_reset();
    bp_en = 1; bp_addr = 32'h10; pc = 0;
    cmd(2'b00, 0); tick(); cmd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(4 * i); #1; chk("bp_run_ce", 32'(cpu_ce), 1); chk("bp_run_halted", 32'(halted), 0); tick();
    end
    pc = 32'h10; #1; chk("bp_hit_ce", 32'(cpu_ce), 0); tick();
    #1; chk("bp_halted", 32'(halted), 1); chk("bp_cnt", cycle_cnt, 4); chk("bp_halt_ce", 32'(cpu_ce), 0);
    cmd(2'b00, 0); tick();
    cmd(2'b10, 0); #1; chk("resume_first_ce", 32'(cpu_ce), 1); tick(); cmd_valid = 0;
    #1; chk("resume_halted", 32'(halted), 1); chk("resume_cnt", cycle_cnt, 5);
    bp_en = 0;
    cmd(2'b11, 0); tick(); cmd_valid = 0;
    hs = 0; exp_idx = 0;
    for (int c = 0; c < 300 && hs < 32; c++) begin
      dump_ready = (c % 3) != 2;
      #1;
      chk("dump_ce", 32'(cpu_ce), 0);
      if (dump_valid) begin
        chk("dump_idx", 32'(dump_idx), 32'(exp_idx));
        chk("dump_data", dump_data, 32'hA500_0000 + 32'(exp_idx));
        if (dump_ready) begin hs++; exp_idx++; end
      end
      tick();
    end
    dump_ready = 0;
    chk("dump_handshakes", 32'(hs), 32);
    #1; chk("dump_halted", 32'(halted), 1); chk("dump_regsel", 32'(reg_sel), 0);
    chk("dump_valid_off", 32'(dump_valid), 0); chk("dump_cnt", cycle_cnt, 5);
    do_reset();
    cmd(2'b00, 0); tick(); cmd_valid = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 2) cmd(2'b01, 16'd5);
      else if (i == 3) cmd(2'b11, 0);
      else if (i == 6) cmd(2'b10, 0);
      else cmd_valid = 0;
      #1; chk("runhalt_ce", 32'(cpu_ce), 1); chk("runhalt_halted", 32'(halted), 0); tick();
    end
    cmd_valid = 0;
    #1; chk("runhalt_off_ce", 32'(cpu_ce), 0); chk("runhalt_halted_end", 32'(halted), 1);
    chk("runhalt_cnt", cycle_cnt, 6);
    cmd(2'b11, 0); tick(); cmd_valid = 0;
    dump_ready = 1;
    begin
      bit found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
        #1;
        if (dump_valid && dump_idx == 5'd7) found = 1; else tick();
      end
      chk("reach_idx7", 32'(found), 1);
    end
    chk("pre_rst_valid", 32'(dump_valid), 1);
    rst = 1; tick(); rst = 0; dump_ready = 0;
    chk("mid_rst_valid", 32'(dump_valid), 0); chk("mid_rst_idx", 32'(dump_idx), 0);
    chk("mid_rst_regsel", 32'(reg_sel), 0); chk("mid_rst_halted", 32'(halted), 1);
    chk("mid_rst_cnt", cycle_cnt, 0); chk("mid_rst_data", dump_data, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
